// File: rtl/mux_rr_arbiter_pkg.sv
// ============================================================================
//  Module   : mux_rr_arbiter_pkg
//  Purpose  : Shared types and constants for the round-robin 4:1 mux arbiter.
//             Holds the arbiter state encoding, requester count, select width
//             and an index-to-one-hot helper.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package mux_rr_arbiter_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick4.sv
// ============================================================================
//  Module   : rr_pick4
//  Purpose  : Combinational rotating priority picker over four requests.
//             Scans start, start+1, start+2, start+3 (mod 4); the first set
//             request wins.
//  Ports    : i_req   [3:0] request vector
//             i_start [1:0] index searched first
//             o_idx   [1:0] winning index (i_start when nothing is requested)
//             o_found       high when any request is set
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_pick4
    import mux_rr_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] i_req,
    input  logic [SEL_W-1:0] i_start,
    output logic [SEL_W-1:0] o_idx,
    output logic             o_found
);

    logic [SEL_W-1:0] w_cand;

    // Walk from the farthest offset back to the nearest so the nearest set
    // request overwrites any later one. The 2-bit sum wraps 3 -> 0 naturally.
    always_comb begin
        o_idx   = i_start;
        o_found = |i_req;
        w_cand  = i_start;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_cand = i_start + SEL_W'(k);
            if (i_req[w_cand]) begin
                o_idx = w_cand;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mux_rr_arbiter.sv
// ============================================================================
//  Module   : mux_rr_arbiter
//  Purpose  : Round-robin arbiter sharing one 4:1 single-bit mux between four
//             requesters, with a hold limit that forces rotation.
//  Ports    : i_clk        clock, rising edge
//             i_rst        asynchronous active-high reset
//             i_req  [3:0] request per requester
//             i_a    [3:0] data bit per requester
//             o_gnt  [3:0] registered one-hot grant, zero when idle
//             o_sel  [1:0] registered mux select
//             o_valid      registered, high while a grant is active
//             o_o          i_a[o_sel] when o_valid, else 0 (combinational)
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mux_rr_arbiter
    import mux_rr_arbiter_pkg::*;
#(
    parameter int HOLD_MAX = 4,
    parameter int HOLD_W   = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_REQ-1:0] i_req,
    input  logic [N_REQ-1:0] i_a,
    output logic [N_REQ-1:0] o_gnt,
    output logic [SEL_W-1:0] o_sel,
    output logic             o_valid,
    output logic             o_o
);

    state_t            r_state, w_state_nxt;
    logic [SEL_W-1:0]  r_ptr,   w_ptr_nxt;
    logic [HOLD_W-1:0] r_cnt,   w_cnt_nxt;
    logic [N_REQ-1:0]  r_gnt,   w_gnt_nxt;
    logic [SEL_W-1:0]  r_sel,   w_sel_nxt;
    logic              r_valid, w_valid_nxt;

    logic [SEL_W-1:0]  w_start;
    logic [SEL_W-1:0]  w_win;
    logic              w_found;

    // While idle the search starts at the priority pointer; while granting
    // the only search that matters is the release search, which starts just
    // after the current owner.
    assign w_start = (r_state == GRANT) ? r_sel + SEL_W'(1) : r_ptr;

    rr_pick4 u_pick (
        .i_req   (i_req),
        .i_start (w_start),
        .o_idx   (w_win),
        .o_found (w_found)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_gnt   <= '0;
            r_sel   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_gnt   <= w_gnt_nxt;
            r_sel   <= w_sel_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_gnt_nxt   = r_gnt;
        w_sel_nxt   = r_sel;
        w_valid_nxt = r_valid;

        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_sel_nxt   = w_win;
                    w_gnt_nxt   = onehot(w_win);
                    w_valid_nxt = 1'b1;
                    w_cnt_nxt   = HOLD_W'(1);
                    w_state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (i_req[r_sel] && (r_cnt < HOLD_W'(HOLD_MAX))) begin
                    w_cnt_nxt = r_cnt + HOLD_W'(1);
                end else begin
                    // Release: rotate priority past the owner. A winner takes
                    // over on this same edge; the owner may win again only if
                    // it is the sole requester.
                    w_ptr_nxt = r_sel + SEL_W'(1);
                    if (w_found) begin
                        w_sel_nxt = w_win;
                        w_gnt_nxt = onehot(w_win);
                        w_cnt_nxt = HOLD_W'(1);
                    end else begin
                        // SEL intentionally keeps its last value.
                        w_gnt_nxt   = '0;
                        w_valid_nxt = 1'b0;
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign o_gnt   = r_gnt;
    assign o_sel   = r_sel;
    assign o_valid = r_valid;
    assign o_o     = r_valid ? i_a[r_sel] : 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_mux_rr_arbiter.sv
`default_nettype none

module tb_mux_rr_arbiter;

    localparam int HOLD_MAX = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] a   = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
    logic       o;

    int checks   = 0;
    int failures = 0;

    // Reference model: owner index, busy flag, hold count and pointer as
    // plain integers.
    int m_ptr  = 0;
    int m_sel  = 0;
    int m_cnt  = 0;
    bit m_busy = 1'b0;

    mux_rr_arbiter #(.HOLD_MAX(HOLD_MAX), .HOLD_W(3)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_req   (req),
        .i_a     (a),
        .o_gnt   (gnt),
        .o_sel   (sel),
        .o_valid (valid),
        .o_o     (o)
    );

    always #5 clk = ~clk;

    function automatic int search(input int start, input logic [3:0] r);
        for (int k = 0; k < 4; k++) begin
            if (r[(start + k) % 4]) return (start + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_sel = 0; m_cnt = 0; m_busy = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] r);
        int w;
        if (!m_busy) begin
            w = search(m_ptr, r);
            if (w >= 0) begin m_busy = 1'b1; m_sel = w; m_cnt = 1; end
        end else if (r[m_sel] && m_cnt < HOLD_MAX) begin
            m_cnt = m_cnt + 1;
        end else begin
            m_ptr = (m_sel + 1) % 4;
            w = search(m_ptr, r);
            if (w >= 0) begin m_sel = w; m_cnt = 1; end
            else m_busy = 1'b0;
        end
    endtask

    // Drive inputs, take one rising edge, advance the model, settle 1 time unit.
    task automatic tick(input logic [3:0] r, input logic [3:0] d);
        req = r; a = d;
        @(posedge clk);
        model_step(r);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; req = 4'b0000;
        model_reset();
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #2;
        checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
        checks++; if (valid !== 1'b0)  begin failures++; $display("FAIL reset_valid: got %b want 0", valid); end
        @(posedge clk);
        #2 rst = 1'b0;
        model_reset();
        tick(4'b1111, 4'b1111);
        checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL reset_first_gnt: got %b want 0001", gnt); end
        checks++; if (o !== 1'b1)      begin failures++; $display("FAIL reset_first_o: got %b want 1", o); end
        tick(4'b1111, 4'b1111);
        tick(4'b1111, 4'b1111);
        tick(4'b1111, 4'b1111);
        tick(4'b1111, 4'b1111);
        // Mid-grant asynchronous reset: outputs must clear without a clock edge.
        #2 rst = 1'b1;
        #1;
        model_reset();
        checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL midreset_gnt: got %b want 0000", gnt); end
        checks++; if (sel !== 2'd0)    begin failures++; $display("FAIL midreset_sel: got %0d want 0", sel); end
        checks++; if (valid !== 1'b0)  begin failures++; $display("FAIL midreset_valid: got %b want 0", valid); end
        checks++; if (o !== 1'b0)      begin failures++; $display("FAIL midreset_o: got %b want 0", o); end
        @(posedge clk);
        #2 rst = 1'b0;
        tick(4'b1111, 4'b0000);
        checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL postreset_gnt: got %b want 0001", gnt); end
    endtask

    task automatic test_single();
        apply_reset();
        tick(4'b0100, 4'b0100);
        checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL single_gnt: got %b want 0100", gnt); end
        checks++; if (sel !== 2'd2)    begin failures++; $display("FAIL single_sel: got %0d want 2", sel); end
        checks++; if (o !== 1'b1)      begin failures++; $display("FAIL single_o: got %b want 1", o); end
        tick(4'b0000, 4'b0100);
        checks++; if (valid !== 1'b0)  begin failures++; $display("FAIL single_drop_valid: got %b want 0", valid); end
        checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL single_drop_gnt: got %b want 0000", gnt); end
        checks++; if (sel !== 2'd2)    begin failures++; $display("FAIL single_drop_sel: got %0d want 2", sel); end
        checks++; if (o !== 1'b0)      begin failures++; $display("FAIL single_drop_o: got %b want 0", o); end
    endtask

    // All four requesting: owners 0,1,2,3 each for exactly HOLD_MAX cycles.
    task automatic test_rotation();
        logic [3:0] exp;
        apply_reset();
        for (int t = 0; t < 4 * HOLD_MAX; t++) begin
            tick(4'b1111, 4'b0000);
            exp = 4'b0001 << ((t / HOLD_MAX) % 4);
            checks++;
            if (gnt !== exp || valid !== 1'b1) begin
                failures++;
                $display("FAIL rotation_t%0d: got gnt=%b valid=%b want gnt=%b valid=1", t, gnt, valid, exp);
            end
        end
    endtask

    // Continues from owner 3 at its hold limit.
    task automatic test_wrap();
        tick(4'b0001, 4'b0001);
        checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL wrap_gnt: got %b want 0001", gnt); end
        checks++; if (sel !== 2'd0)    begin failures++; $display("FAIL wrap_sel: got %0d want 0", sel); end
        checks++; if (o !== 1'b1)      begin failures++; $display("FAIL wrap_o: got %b want 1", o); end
    endtask

    task automatic test_hog();
        apply_reset();
        for (int t = 0; t < 10; t++) begin
            tick(4'b0010, 4'b0000);
            checks++;
            if (gnt !== 4'b0010 || valid !== 1'b1) begin
                failures++;
                $display("FAIL hog_t%0d: got gnt=%b valid=%b want gnt=0010 valid=1", t, gnt, valid);
            end
        end
    endtask

    task automatic test_early_release();
        apply_reset();
        tick(4'b1010, 4'b1000);
        tick(4'b1010, 4'b1000);
        checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL early_owner: got %b want 0010", gnt); end
        tick(4'b1000, 4'b1000);
        checks++; if (gnt !== 4'b1000) begin failures++; $display("FAIL early_gnt: got %b want 1000", gnt); end
        checks++; if (o !== 1'b1)      begin failures++; $display("FAIL early_o: got %b want 1", o); end
    endtask

    task automatic test_random();
        logic [3:0] r;
        logic [3:0] exp_gnt;
        logic       exp_o;
        apply_reset();
        r = 4'b0000;
        for (int t = 0; t < 400; t++) begin
            // Keep the request pattern stable for a while about half the time
            // so hold limits get exercised.
            if ($urandom_range(1, 0) == 0) r = 4'($urandom);
            tick(r, 4'($urandom));
            exp_gnt = m_busy ? (4'b0001 << m_sel) : 4'b0000;
            exp_o   = m_busy ? a[m_sel] : 1'b0;
            checks++;
            if (gnt !== exp_gnt || valid !== m_busy || sel !== 2'(m_sel) || o !== exp_o) begin
                failures++;
                $display("FAIL random_t%0d: got gnt=%b sel=%0d valid=%b o=%b want gnt=%b sel=%0d valid=%b o=%b",
                         t, gnt, sel, valid, o, exp_gnt, m_sel, m_busy, exp_o);
            end
            // Data changes between edges must reach O with no clock.
            a = 4'($urandom);
            #1;
            exp_o = m_busy ? a[m_sel] : 1'b0;
            checks++;
            if (o !== exp_o) begin
                failures++;
                $display("FAIL random_async_o_t%0d: got %b want %b", t, o, exp_o);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_wrap();
        test_hog();
        test_early_release();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

`default_nettype wire
